// File: rtl/gpio_ctrl_intr_status.sv
// gpio_ctrl_intr_status
// Sticky per-group rising/falling edge interrupt status with write-1-to-clear
// and a masked-OR level interrupt to the CPU.
// Optional feature macro: GPIO_CTRL_INTR_HOLDOFF_EN adds a programmable
// holdoff that keeps irq low for holdoff_cycles cycles after each deassertion.
// Without the macro irq simply follows the registered pending condition.

module gpio_ctrl_intr_status #(
    parameter int NUM_GROUPS = 8,
    parameter int HOLDOFF_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_GROUPS-1:0] posedge_intr_status_set,
    input  logic [NUM_GROUPS-1:0] negedge_intr_status_set,
    input  logic [NUM_GROUPS-1:0] posedge_intr_status_clr,
    input  logic [NUM_GROUPS-1:0] negedge_intr_status_clr,
    input  logic [NUM_GROUPS-1:0] posedge_intr_mask,
    input  logic [NUM_GROUPS-1:0] negedge_intr_mask,
    input  logic [HOLDOFF_W-1:0]  holdoff_cycles,
    output logic [NUM_GROUPS-1:0] posedge_intr_status,
    output logic [NUM_GROUPS-1:0] negedge_intr_status,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERTED = 2'd1,
        ST_HOLDOFF  = 2'd2
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [NUM_GROUPS-1:0] pos_status_q;
    logic [NUM_GROUPS-1:0] pos_status_d;
    logic [NUM_GROUPS-1:0] neg_status_q;
    logic [NUM_GROUPS-1:0] neg_status_d;
    logic                  pending_s;

    // Sticky status update: a set in the same cycle as a clear wins, so no edge is lost.
    always_comb begin
        pos_status_d = (pos_status_q & ~posedge_intr_status_clr) | posedge_intr_status_set;
        neg_status_d = (neg_status_q & ~negedge_intr_status_clr) | negedge_intr_status_set;
    end

    // Status registers; masks never gate accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_status_q <= '0;
            neg_status_q <= '0;
        end else begin
            pos_status_q <= pos_status_d;
            neg_status_q <= neg_status_d;
        end
    end

    assign posedge_intr_status = pos_status_q;
    assign negedge_intr_status = neg_status_q;

    // Interrupt request condition from registered status and the current masks.
    always_comb begin
        pending_s = (|(pos_status_q & posedge_intr_mask)) |
                    (|(neg_status_q & negedge_intr_mask));
    end

`ifdef GPIO_CTRL_INTR_HOLDOFF_EN

    localparam logic [HOLDOFF_W-1:0] CNT_ONE = HOLDOFF_W'(1);

    logic [HOLDOFF_W-1:0] cnt_q;
    logic [HOLDOFF_W-1:0] cnt_d;

    // FSM state and holdoff counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; holdoff_cycles is captured only when irq drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_s) begin
                    state_d = ST_ASSERTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERTED: begin
                if (pending_s) begin
                    state_d = ST_ASSERTED;
                end else if (holdoff_cycles == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = holdoff_cycles;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                // Pending is deliberately ignored; a zero count is treated as expired.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_HOLDOFF;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

`else

    // holdoff_cycles has no function without the holdoff feature.
    logic unused_holdoff_s;
    assign unused_holdoff_s = ^holdoff_cycles;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; irq simply tracks pending one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_s) begin
                    state_d = ST_ASSERTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERTED: begin
                if (pending_s) begin
                    state_d = ST_ASSERTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`endif

    // Output decode: irq comes straight from the state register, so it is glitch-free.
    always_comb begin
        irq = (state_q == ST_ASSERTED);
    end

endmodule

// File: tb/tb_gpio_ctrl_intr_status.sv
// Self-checking bench for gpio_ctrl_intr_status: directed vector table,
// hand-written holdoff/reset sequences and randomized cycles against a
// cycle-level reference model. Follows GPIO_CTRL_INTR_HOLDOFF_EN if defined.

module tb_gpio_ctrl_intr_status;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pset = 8'h00;
    logic [7:0]  nset = 8'h00;
    logic [7:0]  pclr = 8'h00;
    logic [7:0]  nclr = 8'h00;
    logic [7:0]  pmask = 8'h00;
    logic [7:0]  nmask = 8'h00;
    logic [15:0] holdoff = 16'd0;
    logic [7:0]  pstat;
    logic [7:0]  nstat;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [7:0] pset;
        logic [7:0] nset;
        logic [7:0] pclr;
        logic [7:0] nclr;
        logic [7:0] pmask;
        logic [7:0] nmask;
        logic [7:0] exp_pstat;
        logic [7:0] exp_nstat;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[14];

    gpio_ctrl_intr_status #(
        .NUM_GROUPS(8),
        .HOLDOFF_W (16)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .posedge_intr_status_set(pset),
        .negedge_intr_status_set(nset),
        .posedge_intr_status_clr(pclr),
        .negedge_intr_status_clr(nclr),
        .posedge_intr_mask      (pmask),
        .negedge_intr_mask      (nmask),
        .holdoff_cycles         (holdoff),
        .posedge_intr_status    (pstat),
        .negedge_intr_status    (nstat),
        .irq                    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_strobes();
        pset = 8'h00;
        nset = 8'h00;
        pclr = 8'h00;
        nclr = 8'h00;
    endtask

    // Length of the irq-low window between a clear and an immediate new set.
    task automatic measure_low(input logic [15:0] h, input int exp_low, input string name);
        int low;
        holdoff = h;
        pmask = 8'hFF;
        pset = 8'h01;
        tick();
        pset = 8'h00;
        tick();
        chk({name, "_pre_irq"}, 32'(irq), 32'd1);
        pclr = 8'h01;
        tick();
        pclr = 8'h00;
        pset = 8'h01;
        tick();
        pset = 8'h00;
        low = 0;
        while (irq == 1'b0 && low < 50) begin
            low++;
            tick();
        end
        chk({name, "_low_cycles"}, 32'(low), 32'(exp_low));
        chk({name, "_irq_back"}, 32'(irq), 32'd1);
        pclr = 8'hFF;
        tick();
        pclr = 8'h00;
        repeat (12) tick();
        holdoff = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // pset nset pclr nclr pmask nmask | pstat nstat irq
        vecs[0]  = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h04, 8'h00, 1'b0};
        vecs[1]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h04, 8'h00, 1'b1};
        vecs[2]  = '{8'h04, 8'h00, 8'h04, 8'h00, 8'hFF, 8'h00, 8'h04, 8'h00, 1'b1};
        vecs[3]  = '{8'h00, 8'h00, 8'h04, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{8'h00, 8'h80, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h80, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h80, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h80, 1'b1};
        vecs[8]  = '{8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 1'b0};
        vecs[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 1'b1};
        vecs[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 1'b0};
        vecs[13] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        // Reset state, both during and after reset.
        #3;
        chk("rst_pstat", 32'(pstat), 32'h0);
        chk("rst_nstat", 32'(nstat), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_irq", 32'(irq), 32'h0);

        // Directed vector table; each row is applied for one edge.
        for (int i = 0; i < 14; i++) begin
            pset  = vecs[i].pset;
            nset  = vecs[i].nset;
            pclr  = vecs[i].pclr;
            nclr  = vecs[i].nclr;
            pmask = vecs[i].pmask;
            nmask = vecs[i].nmask;
            tick();
            chk($sformatf("vec%0d_pstat", i), 32'(pstat), 32'(vecs[i].exp_pstat));
            chk($sformatf("vec%0d_nstat", i), 32'(nstat), 32'(vecs[i].exp_nstat));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end
        zero_strobes();
        tick();

        // Holdoff window lengths.
`ifdef GPIO_CTRL_INTR_HOLDOFF_EN
        measure_low(16'd5, 6, "holdoff5");
        measure_low(16'd1, 2, "holdoff1");
`else
        measure_low(16'd5, 1, "holdoff5");
`endif
        measure_low(16'd0, 1, "holdoff0");

        // Reset in the middle of a holdoff with all status bits set.
        holdoff = 16'd5;
        pmask = 8'hFF;
        nmask = 8'hFF;
        pset = 8'hFF;
        nset = 8'hFF;
        tick();
        zero_strobes();
        tick();
        chk("mid_rst_pre_irq", 32'(irq), 32'd1);
        pclr = 8'hFF;
        nclr = 8'hFF;
        tick();
        zero_strobes();
        pset = 8'hFF;
        nset = 8'hFF;
        tick();
        zero_strobes();
        chk("mid_rst_pstat_ff", 32'(pstat), 32'hFF);
        chk("mid_rst_irq_low", 32'(irq), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pstat", 32'(pstat), 32'h0);
        chk("mid_rst_nstat", 32'(nstat), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("after_rst_irq%0d", i), 32'(irq), 32'd0);
        end
        pset = 8'h01;
        tick();
        pset = 8'h00;
        tick();
        chk("after_rst_new_set_irq", 32'(irq), 32'd1);

        // Randomized cycles against a reference model.
        begin
            logic [7:0] m_ps;
            logic [7:0] m_ns;
            bit         m_irq;
            int         m_allow;
            int         cyc;
            int         hold_eff;
            bit         pend;
            @(negedge clk);
            rst_n = 1'b0;
            zero_strobes();
            #2;
            rst_n = 1'b1;
            m_ps = 8'h00;
            m_ns = 8'h00;
            m_irq = 1'b0;
            m_allow = 0;
            cyc = 0;
            for (int it = 0; it < 400; it++) begin
                pset = 8'($urandom) & 8'($urandom) & 8'($urandom);
                nset = 8'($urandom) & 8'($urandom) & 8'($urandom);
                pclr = 8'($urandom) & 8'($urandom);
                nclr = 8'($urandom) & 8'($urandom);
                if ($urandom_range(0, 7) == 0) pmask = 8'($urandom);
                if ($urandom_range(0, 7) == 0) nmask = 8'($urandom);
                holdoff = 16'($urandom_range(0, 6));
`ifdef GPIO_CTRL_INTR_HOLDOFF_EN
                hold_eff = int'(holdoff);
`else
                hold_eff = 0;
`endif
                // irq decision uses status as it stood before this edge.
                pend = ((m_ps & pmask) != 8'h00) || ((m_ns & nmask) != 8'h00);
                if (m_irq) begin
                    if (!pend) begin
                        m_irq = 1'b0;
                        m_allow = cyc + 1 + hold_eff;
                    end
                end else if (pend && cyc >= m_allow) begin
                    m_irq = 1'b1;
                end
                for (int b = 0; b < 8; b++) begin
                    if (pset[b]) m_ps[b] = 1'b1;
                    else if (pclr[b]) m_ps[b] = 1'b0;
                    if (nset[b]) m_ns[b] = 1'b1;
                    else if (nclr[b]) m_ns[b] = 1'b0;
                end
                tick();
                cyc++;
                chk($sformatf("rand%0d_pstat", it), 32'(pstat), 32'(m_ps));
                chk($sformatf("rand%0d_nstat", it), 32'(nstat), 32'(m_ns));
                chk($sformatf("rand%0d_irq", it), 32'(irq), 32'(m_irq));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
